// File: rtl/jt900h_div_seq.sv
// Multi-cycle DIV/DIVS sequencer for the TLCS-900H: restoring division that borrows
// the shared ALU for one trial subtraction per quotient bit.
module jt900h_div_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic        start,
    input  logic        sgn,
    input  logic        wide,
    input  logic [31:0] dividend,
    input  logic [15:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [15:0] quot,
    output logic [15:0] rem,
    output logic        ovf,
    output logic [5:0]  alu_sel,
    output logic [31:0] alu_op0,
    output logic [31:0] alu_op1,
    output logic [2:0]  alu_w,
    input  logic [31:0] alu_dout,
    input  logic [7:0]  alu_flags
);
    localparam logic [5:0] ALU_MOVE = 6'd0;
    localparam logic [5:0] ALU_SUB  = 6'd2;

    typedef enum logic [2:0] {
        S_IDLE, S_PREP, S_CHK_I, S_CHK_W, S_STEP_I, S_STEP_W, S_FIX
    } state_t;

    state_t      r_state;
    logic        r_sgn, r_wide, r_busy, r_done, r_ovf;
    logic [31:0] r_dvd, r_mag;
    logic [15:0] r_dvs, r_dmag, r_q, r_remmag, r_quot, r_rem;
    logic [3:0]  r_k;
    logic [5:0]  r_alu_sel;
    logic [31:0] r_alu_op0, r_alu_op1;
    logic [2:0]  r_alu_w;

    logic [31:0] w_mask2n, w_mag;
    logic [15:0] w_maskn, w_dmag, w_mag_hi_pre, w_mag_hi, w_r_new;
    logic [15:0] w_q_out, w_r_out, w_raw_q, w_raw_r;
    logic [16:0] w_half;
    logic [3:0]  w_k_top, w_k_dec;
    logic [2:0]  w_issue_w;
    logic        w_dvd_neg, w_dvs_neg, w_neg_q, w_borrow, w_sovf;
    logic        w_unused;

    assign w_unused = ^{alu_dout[31:16], alu_flags[7:1]};

    always_comb begin
        w_mask2n     = r_wide ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        w_maskn      = r_wide ? 16'hFFFF : 16'h00FF;
        w_half       = r_wide ? 17'h0_8000 : 17'h0_0080;
        w_k_top      = r_wide ? 4'd15 : 4'd7;
        w_k_dec      = r_k - 4'd1;
        // Byte mode runs the ALU at word width so the 9-bit shifted remainder fits.
        w_issue_w    = r_wide ? 3'b100 : 3'b010;
        w_dvd_neg    = r_sgn & (r_wide ? r_dvd[31] : r_dvd[15]);
        w_dvs_neg    = r_sgn & (r_wide ? r_dvs[15] : r_dvs[7]);
        w_mag        = (w_dvd_neg ? (~r_dvd + 32'd1) : r_dvd) & w_mask2n;
        w_dmag       = (w_dvs_neg ? (~r_dvs + 16'd1) : r_dvs) & w_maskn;
        w_mag_hi_pre = r_wide ? w_mag[31:16] : {8'h00, w_mag[15:8]};
        w_mag_hi     = r_wide ? r_mag[31:16] : {8'h00, r_mag[15:8]};
        w_borrow     = alu_flags[0];
        // The trial operand still sits in alu_op0, so a borrow just keeps it.
        w_r_new      = w_borrow ? r_alu_op0[15:0] : alu_dout[15:0];
        w_neg_q      = w_dvd_neg ^ w_dvs_neg;
        w_sovf       = r_sgn & (w_neg_q ? ({1'b0, r_q} > w_half) : ({1'b0, r_q} >= w_half));
        w_q_out      = (w_neg_q ? (~r_q + 16'd1) : r_q) & w_maskn;
        w_r_out      = (w_dvd_neg ? (~r_remmag + 16'd1) : r_remmag) & w_maskn;
        w_raw_q      = r_wide ? r_dvd[15:0] : {8'h00, r_dvd[7:0]};
        w_raw_r      = r_wide ? r_dvd[31:16] : {8'h00, r_dvd[15:8]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_sgn     <= 1'b0;
            r_wide    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ovf     <= 1'b0;
            r_dvd     <= '0;
            r_mag     <= '0;
            r_dvs     <= '0;
            r_dmag    <= '0;
            r_q       <= '0;
            r_remmag  <= '0;
            r_quot    <= '0;
            r_rem     <= '0;
            r_k       <= '0;
            r_alu_sel <= ALU_MOVE;
            r_alu_op0 <= '0;
            r_alu_op1 <= '0;
            r_alu_w   <= '0;
        end else if (cen) begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_sgn   <= sgn;
                        r_wide  <= wide;
                        r_dvd   <= dividend;
                        r_dvs   <= divisor;
                        r_ovf   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_PREP;
                    end
                end
                S_PREP: begin
                    r_mag  <= w_mag;
                    r_dmag <= w_dmag;
                    r_q    <= '0;
                    if (w_dmag == 16'd0) begin
                        r_ovf   <= 1'b1;
                        r_state <= S_FIX;
                    end else begin
                        r_alu_sel <= ALU_SUB;
                        r_alu_op0 <= {16'h0000, w_mag_hi_pre};
                        r_alu_op1 <= {16'h0000, w_dmag};
                        r_alu_w   <= w_issue_w;
                        r_state   <= S_CHK_I;
                    end
                end
                S_CHK_I, S_STEP_I: begin
                    r_alu_sel <= ALU_MOVE;
                    r_alu_w   <= 3'b000;
                    r_state   <= (r_state == S_CHK_I) ? S_CHK_W : S_STEP_W;
                end
                S_CHK_W: begin
                    // No borrow means the upper half already reaches the divisor: quotient too wide.
                    if (!w_borrow) begin
                        r_ovf   <= 1'b1;
                        r_state <= S_FIX;
                    end else begin
                        r_k       <= w_k_top;
                        r_alu_sel <= ALU_SUB;
                        r_alu_op0 <= {15'd0, w_mag_hi, r_mag[w_k_top]};
                        r_alu_w   <= w_issue_w;
                        r_state   <= S_STEP_I;
                    end
                end
                S_STEP_W: begin
                    r_q[r_k] <= ~w_borrow;
                    if (r_k == 4'd0) begin
                        r_remmag <= w_r_new;
                        r_state  <= S_FIX;
                    end else begin
                        r_k       <= w_k_dec;
                        r_alu_sel <= ALU_SUB;
                        r_alu_op0 <= {15'd0, w_r_new, r_mag[w_k_dec]};
                        r_alu_w   <= w_issue_w;
                        r_state   <= S_STEP_I;
                    end
                end
                S_FIX: begin
                    if (r_ovf || w_sovf) begin
                        r_ovf  <= 1'b1;
                        r_quot <= w_raw_q;
                        r_rem  <= w_raw_r;
                    end else begin
                        r_quot <= w_q_out;
                        r_rem  <= w_r_out;
                    end
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign quot    = r_quot;
    assign rem     = r_rem;
    assign ovf     = r_ovf;
    assign alu_sel = r_alu_sel;
    assign alu_op0 = r_alu_op0;
    assign alu_op1 = r_alu_op1;
    assign alu_w   = r_alu_w;
endmodule

// File: tb/tb_jt900h_div_seq.sv
// Scoreboard bench for jt900h_div_seq: behavioural ALU, arithmetic reference model,
// decoupled monitor checking quotient, remainder, overflow and latency.
module tb_jt900h_div_seq;
    localparam logic [5:0] ALU_MOVE = 6'd0;
    localparam logic [5:0] ALU_SUB  = 6'd2;
    localparam int LIM = 600;

    logic        clk = 1'b0, rst = 1'b1, cen = 1'b1, start = 1'b0, sgn = 1'b0, wide = 1'b0;
    logic [31:0] dividend = '0;
    logic [15:0] divisor = '0;
    logic        busy, done, ovf;
    logic [15:0] quot, rem;
    logic [5:0]  alu_sel;
    logic [31:0] alu_op0, alu_op1;
    logic [2:0]  alu_w;
    logic [31:0] alu_dout = '0;
    logic [7:0]  alu_flags = '0;

    typedef struct {
        bit          s, w;
        logic [31:0] dd;
        logic [15:0] dv;
        logic [15:0] q, r;
        logic        o;
        int          lat;
        longint      base;
    } exp_t;

    exp_t   sb[$];
    int     n_checks = 0, n_fail = 0, n_txn = 0;
    longint cen_count = 0;
    bit     cen_rand = 1'b0;

    jt900h_div_seq dut (
        .clk(clk), .rst(rst), .cen(cen), .start(start), .sgn(sgn), .wide(wide),
        .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
        .quot(quot), .rem(rem), .ovf(ovf), .alu_sel(alu_sel), .alu_op0(alu_op0),
        .alu_op1(alu_op1), .alu_w(alu_w), .alu_dout(alu_dout), .alu_flags(alu_flags)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (cen) cen_count <= cen_count + 1;

    always @(negedge clk) if (cen_rand) cen = 1'($urandom_range(0, 1));

    // Behavioural ALU: registered result, carry = borrow on SUB at the selected width.
    longint alu_mask, a0, a1;
    always @(posedge clk) begin
        if (cen && alu_w != 3'b000) begin
            alu_mask = alu_w[2] ? 64'hFFFF_FFFF : (alu_w[1] ? 64'hFFFF : 64'hFF);
            a0 = longint'(alu_op0) & alu_mask;
            a1 = longint'(alu_op1) & alu_mask;
            if (alu_sel == ALU_SUB) begin
                alu_dout  <= 32'((a0 - a1) & alu_mask);
                alu_flags <= {7'h00, a0 < a1};
            end else begin
                alu_dout <= 32'(a1);
            end
        end
    end

    task automatic chk(input string name, input longint act, input longint expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, expv);
        end
    endtask

    task automatic bound_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound of %0d cycles expired", name, LIM);
    endtask

    function automatic exp_t model(input bit s, input bit w, input logic [31:0] dd,
                                   input logic [15:0] dv);
        exp_t   e;
        int     n;
        longint a, b, mn, q, r;
        n  = w ? 16 : 8;
        mn = (longint'(1) << n) - 1;
        a  = longint'(dd) & ((longint'(1) << (2 * n)) - 1);
        b  = longint'(dv) & mn;
        e.s = s; e.w = w; e.dd = dd; e.dv = dv;
        e.q = 16'(a & mn);
        e.r = 16'((a >> n) & mn);
        e.o = 1'b1;
        if (b == 0) begin
            e.lat = 3;
            return e;
        end
        if (s && a[2*n-1]) a = a - (longint'(1) << (2 * n));
        if (s && b[n-1])   b = b - (longint'(1) << n);
        if (((a < 0) ? -a : a) / ((b < 0) ? -b : b) >= (longint'(1) << n)) begin
            e.lat = 5;
            return e;
        end
        e.lat = 2 * n + 5;
        q = a / b;
        r = a % b;
        if (s && (q > (longint'(1) << (n - 1)) - 1 || q < -(longint'(1) << (n - 1))))
            return e;
        e.o = 1'b0;
        e.q = 16'(q & mn);
        e.r = 16'(r & mn);
        return e;
    endfunction

    // Monitor: every rising done pops one expectation.
    logic done_q = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1 && done_q !== 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 required no pending operation");
            end else begin
                e = sb.pop_front();
                n_txn++;
                $display("txn %0d sgn=%0d wide=%0d dvd=%h dvs=%h -> quot=%h rem=%h ovf=%0d lat=%0d",
                         n_txn, e.s, e.w, e.dd, e.dv, quot, rem, ovf, cen_count - e.base);
                chk("quot", quot, e.q);
                chk("rem", rem, e.r);
                chk("ovf", ovf, e.o);
                chk("latency", cen_count - e.base, e.lat);
                chk("busy_at_done", busy, 0);
            end
        end
        done_q = done;
    end

    task automatic wait_idle();
        int t = 0;
        while (busy !== 1'b0 && t < LIM) begin
            @(negedge clk);
            t++;
        end
        if (t >= LIM) bound_fail("timeout_idle");
    endtask

    task automatic issue(input bit s, input bit w, input logic [31:0] dd, input logic [15:0] dv);
        exp_t e;
        int   t = 0;
        wait_idle();
        sgn = s; wide = w; dividend = dd; divisor = dv; start = 1'b1;
        do begin
            @(negedge clk);
            t++;
        end while (busy !== 1'b1 && t < LIM);
        start = 1'b0;
        dividend = $urandom;
        divisor = 16'($urandom);
        sgn = 1'($urandom_range(0, 1));
        wide = 1'($urandom_range(0, 1));
        if (t >= LIM) begin
            bound_fail("timeout_accept");
            return;
        end
        e = model(s, w, dd, dv);
        e.base = cen_count - 1;
        sb.push_back(e);
    endtask

    task automatic directed();
        issue(0, 0, 32'h0000_0064, 16'h0007);
        issue(1, 0, 32'h0000_FF9C, 16'h0007);
        issue(0, 1, 32'h0001_86A0, 16'h0100);
        issue(0, 0, 32'h0000_1234, 16'h0000);
        issue(0, 0, 32'h0000_1234, 16'h0010);
        issue(1, 0, 32'h0000_0080, 16'h0001);
        issue(1, 0, 32'h0000_FF80, 16'h0001);
        issue(1, 1, 32'hFFFF_8000, 16'h0001);
        issue(1, 1, 32'hFFFE_0000, 16'hFFFE);
    endtask

    task automatic random_ops(input int count);
        bit          s, w;
        logic [15:0] mn, dv;
        logic [31:0] dd;
        longint      q, r;
        for (int i = 0; i < count; i++) begin
            s  = 1'($urandom_range(0, 1));
            w  = 1'($urandom_range(0, 1));
            mn = w ? 16'hFFFF : 16'h00FF;
            dv = 16'($urandom) & mn;
            if ($urandom_range(0, 3) == 0) begin
                dd = $urandom;
            end else begin
                if (dv == 16'd0) dv = 16'd1;
                q  = longint'($urandom) & longint'(mn);
                r  = longint'($urandom) % longint'(dv);
                dd = 32'(q * longint'(dv) + r);
            end
            issue(s, w, dd, dv);
        end
    endtask

    initial begin
        int t;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_ovf", ovf, 0);
        chk("reset_quot", quot, 0);
        chk("reset_rem", rem, 0);
        chk("reset_alu_w", alu_w, 0);
        chk("reset_alu_sel", alu_sel, ALU_MOVE);
        chk("reset_alu_op0", alu_op0, 0);
        rst = 1'b0;
        @(negedge clk);

        directed();
        random_ops(60);

        cen_rand = 1'b1;
        directed();
        random_ops(20);
        wait_idle();
        @(negedge clk);
        cen_rand = 1'b0;
        @(negedge clk);
        cen = 1'b1;

        // Reset in the middle of the bit loop, with cen low to show it is ignored.
        wait_idle();
        @(negedge clk);
        sgn = 1'b0; wide = 1'b1; dividend = 32'h0001_86A0; divisor = 16'h0100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        chk("busy_mid_step", busy, 1);
        cen = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cen = 1'b1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        chk("rst_mid_quot", quot, 0);
        chk("rst_mid_rem", rem, 0);
        chk("rst_mid_alu_w", alu_w, 0);
        repeat (60) @(negedge clk);
        chk("rst_no_resume", busy, 0);

        issue(0, 0, 32'h0000_0064, 16'h0007);
        t = 0;
        while ((sb.size() != 0 || busy !== 1'b0) && t < LIM) begin
            @(negedge clk);
            t++;
        end
        if (t >= LIM) bound_fail("timeout_drain");
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
